// File: rtl/hazard_scoreboard.sv
// Producer-side hazard scoreboard for the five-stage MIPS pipeline.
// Tracks in-flight GPR writers (EX/MEM/WB) and the HI/LO unit; raises stall when forwarding cannot help.
module hazard_scoreboard #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ra1_id,
    input  logic [4:0] ra2_id,
    input  logic [1:0] tuse1_id,
    input  logic [1:0] tuse2_id,
    input  logic [4:0] wa_id,
    input  logic [1:0] tnew_id,
    input  logic       md_start_id,
    input  logic       md_isdiv_id,
    input  logic       md_use_id,
    input  logic       flush,
    output logic       stall,
    output logic       md_busy,
    output logic [1:0] tnew_ex
);

    logic [4:0] ex_wa_q, ex_wa_d, mem_wa_q, mem_wa_d, wb_wa_q, wb_wa_d;
    logic [1:0] ex_tnew_q, ex_tnew_d, mem_tnew_q, mem_tnew_d, wb_tnew_q, wb_tnew_d;
    logic [3:0] md_cnt_q, md_cnt_d;
    logic       md_pend_q, md_pend_d;
    logic       md_isdiv_q, md_isdiv_d;

    logic hazard_1, hazard_2, md_hazard;

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Youngest matching writer decides, mirroring the forwarding mux priority.
    function automatic logic operand_hazard(
        input logic [4:0] ra, input logic [1:0] tuse,
        input logic [4:0] ex_wa, input logic [1:0] ex_tnew,
        input logic [4:0] mem_wa, input logic [1:0] mem_tnew,
        input logic [4:0] wb_wa, input logic [1:0] wb_tnew
    );
        logic hz;
        hz = 1'b0;
        if (tuse != 2'd3 && ra != 5'd0) begin
            if (ex_wa == ra)       hz = (ex_tnew > tuse);
            else if (mem_wa == ra) hz = (mem_tnew > tuse);
            else if (wb_wa == ra)  hz = (wb_tnew > tuse);
        end
        return hz;
    endfunction

    always_comb begin
        hazard_1  = operand_hazard(ra1_id, tuse1_id, ex_wa_q, ex_tnew_q,
                                   mem_wa_q, mem_tnew_q, wb_wa_q, wb_tnew_q);
        hazard_2  = operand_hazard(ra2_id, tuse2_id, ex_wa_q, ex_tnew_q,
                                   mem_wa_q, mem_tnew_q, wb_wa_q, wb_tnew_q);
        md_busy   = (md_cnt_q != 4'd0);
        md_hazard = (md_start_id | md_use_id) & (md_busy | md_pend_q);
        stall     = hazard_1 | hazard_2 | md_hazard;
        tnew_ex   = ex_tnew_q;
    end

    always_comb begin
        wb_wa_d    = mem_wa_q;
        wb_tnew_d  = sat_dec(mem_tnew_q);
        mem_wa_d   = ex_wa_q;
        mem_tnew_d = sat_dec(ex_tnew_q);
        ex_wa_d    = stall ? 5'd0 : wa_id;
        ex_tnew_d  = stall ? 2'd0 : tnew_id;
        if (flush) begin
            wb_wa_d    = 5'd0;
            wb_tnew_d  = 2'd0;
            mem_wa_d   = 5'd0;
            mem_tnew_d = 2'd0;
            ex_wa_d    = 5'd0;
            ex_tnew_d  = 2'd0;
        end

        // A flushed pending op never starts counting; a running count is left alone.
        md_pend_d  = md_start_id & ~stall & ~flush;
        md_isdiv_d = md_pend_d ? md_isdiv_id : md_isdiv_q;
        md_cnt_d   = md_cnt_q;
        if (md_pend_q && !flush)
            md_cnt_d = md_isdiv_q ? 4'(DIV_LAT) : 4'(MULT_LAT);
        else if (md_cnt_q != 4'd0)
            md_cnt_d = md_cnt_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_wa_q    <= 5'd0;
            ex_tnew_q  <= 2'd0;
            mem_wa_q   <= 5'd0;
            mem_tnew_q <= 2'd0;
            wb_wa_q    <= 5'd0;
            wb_tnew_q  <= 2'd0;
            md_cnt_q   <= 4'd0;
            md_pend_q  <= 1'b0;
            md_isdiv_q <= 1'b0;
        end else begin
            ex_wa_q    <= ex_wa_d;
            ex_tnew_q  <= ex_tnew_d;
            mem_wa_q   <= mem_wa_d;
            mem_tnew_q <= mem_tnew_d;
            wb_wa_q    <= wb_wa_d;
            wb_tnew_q  <= wb_tnew_d;
            md_cnt_q   <= md_cnt_d;
            md_pend_q  <= md_pend_d;
            md_isdiv_q <= md_isdiv_d;
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side companion to the operand-forwarding muxes in the five-stage MIPS pipeline.
- Tracks every in-flight GPR writer through EX/MEM/WB, with its destination and remaining cycles until the result is forwardable (Tnew).
- Tracks the multi-cycle HI/LO unit.
- Compares this against the consumer requirements of the instruction in ID (Tuse) and raises stall when forwarding cannot yet supply a correct value.

Parameters:
- MULT_LAT, 5, busy cycles of the HI/LO unit for mult/multu
- DIV_LAT, 10, busy cycles of the HI/LO unit for div/divu

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  synchronous, active-low reset
- ra1_id  input  5  rs index of the ID instruction
- ra2_id  input  5  rt index of the ID instruction
- tuse1_id  input  2  cycles until rs is consumed (0 = ID, 1 = EX, 2 = MEM, 3 = not used)
- tuse2_id  input  2  same encoding for rt
- wa_id  input  5  destination of the ID instruction (0 = no write)
- tnew_id  input  2  cycles after entering EX until the result is forwardable (0 jal/lui-like, 1 ALU, 2 load)
- md_start_id  input  1  ID instruction is mult/multu/div/divu
- md_isdiv_id  input  1  qualifies md_start_id: 1 = div class
- md_use_id  input  1  ID instruction is mfhi/mflo/mthi/mtlo
- flush  input  1  exception/eret flush of EX, MEM and WB
- stall  output  1  freeze PC and IF/ID, inject bubble into ID/EX
- md_busy  output  1  HI/LO unit is busy
- tnew_ex  output  2  current Tnew of the EX entry (debug/forward qualification)

Behaviour:
- State:
  - Three entries {wa[4:0], tnew[1:0]} for EX, MEM and WB.
  - md_cnt[3:0].
  - md_pend: an md op is in EX and has not yet started counting.
- Reset (reset==0 at a posedge):
  - All entries set to wa=0, tnew=0.
  - md_cnt=0, md_pend=0.
  - Outputs settle to stall=0, md_busy=0, tnew_ex=0.
- Advance each posedge, when not in reset:
  - WB <= {MEM.wa, sat_dec(MEM.tnew)}.
  - MEM <= {EX.wa, sat_dec(EX.tnew)}.
  - sat_dec(0)=0.
  - EX <= stall ? {0,0} : {wa_id, tnew_id}.
- Flush overrides the advance:
  - EX, MEM and WB all load {0,0}.
  - md_pend cleared.
  - A count already running in md_cnt continues.
- GPR hazard, evaluated combinationally per operand i:
  - Skip the operand if tusei_id==3 or rai_id==0.
  - Search for wa==rai in stage priority EX, then MEM, then WB. Only the first match counts, so the youngest writer wins, matching forwarding priority.
  - hazard_i = match_found && match.tnew > tusei_id.
- HI/LO hazard:
  - md_hazard = (md_start_id | md_use_id) && (md_busy | md_pend).
- Output equations:
  - stall = hazard_1 | hazard_2 | md_hazard.
  - md_busy = (md_cnt != 0).
- HI/LO counter:
  - When an md op issues (md_start_id & ~stall & ~flush), md_pend <= 1 and the latency class is latched.
  - The next cycle: md_pend <= 0 and md_cnt <= (class ? DIV_LAT : MULT_LAT).
  - Otherwise md_cnt decrements while nonzero.
  - Simultaneous issue and countdown cannot occur, because md_hazard blocks issue while busy.
- Boundaries:
  - Writer with wa=0 never matches.
  - stall asserted with flush: flush wins for state. stall is still driven combinationally, and the front end gives flush priority.
  - Reset mid-count aborts the count to 0.
  - Repeated hits on the same register: only the youngest entry is considered, even if an older entry has tnew=0.
- No latency on stall: the same-cycle combinational function of ID inputs and registered state.

Test Plan:
- Load-use: lw $8 issues (wa=8, tnew=2), next ID is addu using $8 with tuse=1. Required: stall=1 for exactly 1 cycle, then EX holds a bubble, MEM holds $8 with tnew=1, and stall=0.
- Branch after ALU: addu $9 (tnew=1) issued, next ID is beq on $9 with tuse=0. Required: stall=1 for 1 cycle. Repeat with a jal-like writer (tnew=0): stall stays 0.
- Youngest wins: EX={5, tnew 0} and MEM={5, tnew 1}, ID reads $5 with tuse=0. Required: stall=0.
- Zero register: writer wa=0 with tnew=2, ID reads $0 with tuse=0. Required: stall=0.
- Divide busy: div issued with DIV_LAT=10, then mflo in ID. Required: md_busy rises the cycle after md_pend, and stall holds until md_cnt reaches 0 (11 stalled cycles from issue). mult with MULT_LAT=5 gives 6 stalled cycles.
- Flush and reset:
  - flush with lw in EX: all entries are zero the next cycle, and a dependent ID instruction is not stalled.
  - reset=0 during an active div count: md_busy=0 the next cycle.
